// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the 3-digit 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits on the result write.
module bin_a_bcd #(
  parameter int unsigned N_BITS  = 10,
  parameter int unsigned MAX_VAL = 999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] dato,
  output logic              busy,
  output logic              listo,
  output logic              ovf,
  output logic [4:0]        u,
  output logic [4:0]        d,
  output logic [4:0]        c
);

  localparam int unsigned W  = N_BITS + 12;
  localparam int unsigned CW = $clog2(N_BITS + 1);
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] ERR   = 5'h0E;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [4:0] RST_DC = BLANK;
`else
  localparam logic [4:0] RST_DC = 5'h00;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   sh, sh_adj, sh_step;
  logic [CW-1:0]  cnt;
  logic           ovf_pend;
  logic           over;
  logic [4:0]     dig_c, dig_d, dig_u;

  assign over = 32'(dato) > 32'(MAX_VAL);

  always_comb begin
    sh_adj = sh;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sh_adj[N_BITS + 4*i +: 4] >= 4'd5)
        sh_adj[N_BITS + 4*i +: 4] = sh_adj[N_BITS + 4*i +: 4] + 4'd3;
    end
    sh_step = {sh_adj[W-2:0], 1'b0};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = over ? DONE : SHIFT;
      SHIFT:   if (cnt == CW'(N_BITS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dig_c = {1'b0, sh[W-1 -: 4]};
    dig_d = {1'b0, sh[W-5 -: 4]};
    dig_u = {1'b0, sh[W-9 -: 4]};
`ifdef LEADING_ZERO_BLANK_EN
    // d is only blanked when the hundreds digit is also zero
    if (sh[W-1 -: 4] == 4'd0) begin
      dig_c = BLANK;
      if (sh[W-5 -: 4] == 4'd0) dig_d = BLANK;
    end
`endif
  end

  // listo is registered out of DONE, so the result appears one edge after DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      listo    <= 1'b0;
      ovf      <= 1'b0;
      u        <= 5'h00;
      d        <= RST_DC;
      c        <= RST_DC;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      listo <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ovf_pend <= over;
            sh       <= W'(dato);
            cnt      <= '0;
          end
        end
        SHIFT: begin
          sh  <= sh_step;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (ovf_pend) begin
            ovf <= 1'b1;
            c   <= ERR;
            d   <= BLANK;
            u   <= BLANK;
          end else begin
            ovf <= 1'b0;
            c   <= dig_c;
            d   <= dig_d;
            u   <= dig_u;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
